// File: rtl/store_lane_steer.sv
// store_lane_steer: RV32I memory-stage store unit.
// Steers store data into word-aligned byte lanes with byte enables and issues
// the result to data memory over a req/ack handshake.
// Optional feature macro: STORE_SPLIT_MISALIGNED_EN
//   defined   -> misaligned stores are split into two bus beats
//   undefined -> misaligned stores are rejected with an st_err pulse
module store_lane_steer #(
  parameter int ADDR_W      = 32,
  parameter int ACK_TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic [1:0]        st_size,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  output logic              st_err
);

  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

`ifdef STORE_SPLIT_MISALIGNED_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BEAT0 = 2'd1, S_BEAT1 = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BEAT0 = 2'd1} state_t;
`endif

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              go_idle;

  logic [1:0]        off;
  logic [3:0]        mask4;
  logic [7:0]        mask8;
  logic [3:0]        be0;
  logic [3:0]        be1;
  logic [31:0]       wdata0;
  logic [ADDR_W-1:0] base_addr;
  logic              misaligned;
  logic              reserved;
  logic              timeout_hit;

`ifdef STORE_SPLIT_MISALIGNED_EN
  logic              split_q, split_d;
  logic [ADDR_W-1:0] addr1_q, addr1_d;
  logic [31:0]       wdata1_q, wdata1_d;
  logic [3:0]        be1_q, be1_d;
  logic [31:0]       wdata1;
  logic [ADDR_W-1:0] next_addr;
`endif

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Base enable pattern for the requested access size.
  always_comb begin
    mask4 = 4'b0000;
    case (st_size)
      2'b00:   mask4 = 4'b0001;
      2'b01:   mask4 = 4'b0011;
      2'b10:   mask4 = 4'b1111;
      default: mask4 = 4'b0000;
    endcase
  end

  assign off        = st_addr[1:0];
  assign mask8      = {4'b0000, mask4} << off;
  assign be0        = mask8[3:0];
  assign be1        = mask8[7:4];
  assign misaligned = |be1;
  assign reserved   = (st_size == 2'b11);
  assign wdata0     = (st_data << {off, 3'b000}) & lane_mask(be0);
  assign base_addr  = {st_addr[ADDR_W-1:2], 2'b00};

`ifdef STORE_SPLIT_MISALIGNED_EN
  assign wdata1    = (st_data >> (6'd32 - {1'b0, off, 3'b000})) & lane_mask(be1);
  assign next_addr = base_addr + ADDR_W'(4);
`endif

  assign timeout_hit = (ACK_TIMEOUT > 0) && (cnt_q == CNT_W'(ACK_TIMEOUT - 1));

  // Next-state and next-output logic for the beat sequencer.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q + CNT_W'(1);
    go_idle = 1'b0;
`ifdef STORE_SPLIT_MISALIGNED_EN
    split_d  = split_q;
    addr1_d  = addr1_q;
    wdata1_d = wdata1_q;
    be1_d    = be1_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (st_valid) begin
          if (reserved) begin
            err_d = 1'b1;
          end
`ifndef STORE_SPLIT_MISALIGNED_EN
          else if (misaligned) begin
            err_d = 1'b1;
          end
`endif
          else begin
            state_d = S_BEAT0;
            req_d   = 1'b1;
            addr_d  = base_addr;
            wdata_d = wdata0;
            be_d    = be0;
`ifdef STORE_SPLIT_MISALIGNED_EN
            split_d  = misaligned;
            addr1_d  = next_addr;
            wdata1_d = wdata1;
            be1_d    = be1;
`endif
          end
        end
      end
      S_BEAT0: begin
        if (mem_ack) begin
`ifdef STORE_SPLIT_MISALIGNED_EN
          if (split_q) begin
            state_d = S_BEAT1;
            addr_d  = addr1_q;
            wdata_d = wdata1_q;
            be_d    = be1_q;
            cnt_d   = '0;
          end else begin
            go_idle = 1'b1;
          end
`else
          go_idle = 1'b1;
`endif
        end else if (timeout_hit) begin
          go_idle = 1'b1;
          err_d   = 1'b1;
        end
      end
`ifdef STORE_SPLIT_MISALIGNED_EN
      S_BEAT1: begin
        if (mem_ack) begin
          go_idle = 1'b1;
        end else if (timeout_hit) begin
          go_idle = 1'b1;
          err_d   = 1'b1;
        end
      end
`endif
      default: begin
        go_idle = 1'b1;
      end
    endcase
    if (go_idle) begin
      state_d = S_IDLE;
      req_d   = 1'b0;
      addr_d  = '0;
      wdata_d = '0;
      be_d    = '0;
`ifdef STORE_SPLIT_MISALIGNED_EN
      split_d = 1'b0;
`endif
    end
  end

  // State and registered bus outputs; reset abandons any transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef STORE_SPLIT_MISALIGNED_EN
  // Second-beat payload captured at accept time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      split_q  <= 1'b0;
      addr1_q  <= '0;
      wdata1_q <= '0;
      be1_q    <= '0;
    end else begin
      split_q  <= split_d;
      addr1_q  <= addr1_d;
      wdata1_q <= wdata1_d;
      be1_q    <= be1_d;
    end
  end
`endif

  assign st_ready  = (state_q == S_IDLE);
  assign mem_req   = req_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign st_err    = err_q;

endmodule

// File: tb/tb_store_lane_steer.sv
// Directed testbench for store_lane_steer (ACK_TIMEOUT=4).
// Follows STORE_SPLIT_MISALIGNED_EN to pick split or reject expectations.
module tb_store_lane_steer;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        st_err;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  store_lane_steer #(
    .ADDR_W      (32),
    .ACK_TIMEOUT (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_size   (st_size),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .st_err    (st_err)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] a,
                               input logic [31:0] d, input logic [1:0] s);
    st_valid = v;
    st_addr  = a;
    st_data  = d;
    st_size  = s;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkBeat(input string tag, input logic [31:0] a,
                           input logic [3:0] be, input logic [31:0] d);
    checkOutput({tag, " req"},   32'(mem_req), 32'd1);
    checkOutput({tag, " addr"},  mem_addr, a);
    checkOutput({tag, " be"},    32'(mem_be), 32'(be));
    checkOutput({tag, " wdata"}, mem_wdata, d);
  endtask

  initial begin
    rst_n    = 1'b0;
    mem_ack  = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00);
    #12;
    checkOutput("rst req",   32'(mem_req), 32'd0);
    checkOutput("rst addr",  mem_addr, 32'd0);
    checkOutput("rst wdata", mem_wdata, 32'd0);
    checkOutput("rst be",    32'(mem_be), 32'd0);
    checkOutput("rst err",   32'(st_err), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    checkOutput("rst ready", 32'(st_ready), 32'd1);

    // Aligned word with three wait cycles.
    applyStimulus(1'b1, 32'h100, 32'hDEADBEEF, 2'b10);
    step();
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00);
    checkBeat("word", 32'h100, 4'b1111, 32'hDEADBEEF);
    checkOutput("word ready busy", 32'(st_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkBeat("word hold", 32'h100, 4'b1111, 32'hDEADBEEF);
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    checkOutput("word done req", 32'(mem_req), 32'd0);
    checkOutput("word done ready", 32'(st_ready), 32'd1);

    // Byte store into the top lane.
    applyStimulus(1'b1, 32'h203, 32'h000000A5, 2'b00);
    step();
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00);
    checkBeat("byte", 32'h200, 4'b1000, 32'hA5000000);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    checkOutput("byte done req", 32'(mem_req), 32'd0);

`ifdef STORE_SPLIT_MISALIGNED_EN
    // Misaligned word split across two beats.
    applyStimulus(1'b1, 32'h0FE, 32'h11223344, 2'b10);
    step();
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00);
    checkBeat("split word b0", 32'h0FC, 4'b1100, 32'h33440000);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    checkBeat("split word b1", 32'h100, 4'b0011, 32'h00001122);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    checkOutput("split word done", 32'(mem_req), 32'd0);

    // Misaligned half at offset 3.
    applyStimulus(1'b1, 32'h7, 32'h0000BBAA, 2'b01);
    step();
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00);
    checkBeat("split half b0", 32'h4, 4'b1000, 32'hAA000000);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    checkBeat("split half b1", 32'h8, 4'b0001, 32'h000000BB);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    checkOutput("split half done", 32'(mem_req), 32'd0);
`else
    // Misaligned stores are rejected.
    applyStimulus(1'b1, 32'h0FE, 32'h11223344, 2'b10);
    step();
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00);
    checkOutput("misal word err", 32'(st_err), 32'd1);
    checkOutput("misal word req", 32'(mem_req), 32'd0);
    applyStimulus(1'b1, 32'h7, 32'h0000BBAA, 2'b01);
    step();
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00);
    checkOutput("misal half err", 32'(st_err), 32'd1);
    checkOutput("misal half req", 32'(mem_req), 32'd0);
    step();
    checkOutput("misal half err end", 32'(st_err), 32'd0);
    checkOutput("misal half req end", 32'(mem_req), 32'd0);
`endif

    // Reserved size.
    applyStimulus(1'b1, 32'h40, 32'h12345678, 2'b11);
    step();
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00);
    checkOutput("rsv err", 32'(st_err), 32'd1);
    checkOutput("rsv req", 32'(mem_req), 32'd0);
    checkOutput("rsv ready", 32'(st_ready), 32'd1);
    step();
    checkOutput("rsv err end", 32'(st_err), 32'd0);
    checkOutput("rsv req end", 32'(mem_req), 32'd0);

    // Ack timeout after four cycles.
    applyStimulus(1'b1, 32'h300, 32'hCAFEF00D, 2'b10);
    step();
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00);
    for (int i = 0; i < 4; i++) begin
      checkOutput("to req high", 32'(mem_req), 32'd1);
      checkOutput("to err low", 32'(st_err), 32'd0);
      step();
    end
    checkOutput("to req drop", 32'(mem_req), 32'd0);
    checkOutput("to err", 32'(st_err), 32'd1);
    checkOutput("to ready", 32'(st_ready), 32'd1);
    step();
    checkOutput("to err end", 32'(st_err), 32'd0);

    // Reset while waiting on the last beat.
`ifdef STORE_SPLIT_MISALIGNED_EN
    applyStimulus(1'b1, 32'h0FE, 32'h11223344, 2'b10);
    step();
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    checkBeat("pre rst b1", 32'h100, 4'b0011, 32'h00001122);
`else
    applyStimulus(1'b1, 32'h500, 32'h0BADBEEF, 2'b10);
    step();
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00);
    checkBeat("pre rst b0", 32'h500, 4'b1111, 32'h0BADBEEF);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid rst req",   32'(mem_req), 32'd0);
    checkOutput("mid rst addr",  mem_addr, 32'd0);
    checkOutput("mid rst wdata", mem_wdata, 32'd0);
    checkOutput("mid rst be",    32'(mem_be), 32'd0);
    checkOutput("mid rst err",   32'(st_err), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    checkOutput("post rst ready", 32'(st_ready), 32'd1);
    checkOutput("post rst req", 32'(mem_req), 32'd0);
    applyStimulus(1'b1, 32'h10, 32'h12345678, 2'b10);
    step();
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00);
    checkBeat("post rst word", 32'h10, 4'b1111, 32'h12345678);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    checkOutput("post rst done req", 32'(mem_req), 32'd0);
    checkOutput("post rst done ready", 32'(st_ready), 32'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
